// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Single-outstanding instruction fetch stage with a valid/ready IR
//            handshake, one PCinc pulse per captured instruction and
//            flush/redirect. Optional macro FETCH_TIMEOUT_EN adds a memAck
//            watchdog that parks the unit in a sticky error state.
// Revision : 1.0  initial release
// ============================================================================
module fetch_unit #(
  parameter int n       = 32,
  parameter int TIMEOUT = 15
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         run,
  input  logic         flush,
  input  logic [n-1:0] PCaddr,
  output logic         PCinc,
  output logic         memReq,
  output logic [n-1:0] memAddr,
  input  logic [n-1:0] memRdata,
  input  logic         memAck,
  output logic [n-1:0] IRout,
  output logic         IRvalid,
  input  logic         IRready,
  output logic         fetchErr
);

  localparam logic [2:0] c_IDLE  = 3'd0;
  localparam logic [2:0] c_ADDR  = 3'd1;
  localparam logic [2:0] c_FETCH = 3'd2;
  localparam logic [2:0] c_HOLD  = 3'd3;
  localparam logic [2:0] c_DRAIN = 3'd4;
  localparam logic [2:0] c_ERR   = 3'd5;

  logic [2:0]   r_state;
  logic [2:0]   w_next;
  logic [n-1:0] r_mem_addr;
  logic [n-1:0] r_ir;
  logic         r_pcinc;
  logic         w_mem_req;
  logic         w_ir_valid;
  logic         w_fetch_err;
  logic         w_accept;
  logic         w_timeout;

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_timeout_range
    $error("fetch_unit: TIMEOUT must lie in 1..255");
  end

  // Read completes with data that is kept: the only source of IR loads and PCinc.
  assign w_accept = (r_state == c_FETCH) && memAck && !flush;

`ifdef FETCH_TIMEOUT_EN
  localparam logic [7:0] c_WAIT_LAST = 8'(TIMEOUT - 1);

  logic [7:0] r_wait;
  logic       w_waiting;

  assign w_waiting = ((r_state == c_FETCH) || (r_state == c_DRAIN)) && !memAck;
  assign w_timeout = w_waiting && (r_wait == c_WAIT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait <= 8'd0;
    end else if (w_next != r_state) begin
      r_wait <= 8'd0;
    end else if (w_waiting) begin
      r_wait <= r_wait + 8'd1;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_IDLE: begin
        if (run) w_next = c_ADDR;
      end
      c_ADDR: begin
        // A redirect here simply re-samples the new PC next cycle.
        w_next = flush ? c_ADDR : c_FETCH;
      end
      c_FETCH: begin
        if (memAck)         w_next = flush ? c_ADDR : c_HOLD;
        else if (flush)     w_next = c_DRAIN;
        else if (w_timeout) w_next = c_ERR;
      end
      c_DRAIN: begin
        if (memAck)         w_next = c_ADDR;
        else if (w_timeout) w_next = c_ERR;
      end
      c_HOLD: begin
        if (flush || IRready) w_next = run ? c_ADDR : c_IDLE;
      end
      c_ERR: begin
        w_next = c_ERR;
      end
      default: begin
        w_next = c_IDLE;
      end
    endcase
  end

  always_comb begin
    w_mem_req   = 1'b0;
    w_ir_valid  = 1'b0;
    w_fetch_err = 1'b0;
    case (r_state)
      c_FETCH, c_DRAIN: w_mem_req  = 1'b1;
      c_HOLD:           w_ir_valid = 1'b1;
`ifdef FETCH_TIMEOUT_EN
      c_ERR:            w_fetch_err = 1'b1;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_addr <= '0;
      r_ir       <= '0;
      r_pcinc    <= 1'b0;
    end else begin
      r_pcinc <= w_accept;
      if (r_state == c_ADDR) r_mem_addr <= PCaddr;
      if (w_accept)          r_ir       <= memRdata;
    end
  end

  assign PCinc    = r_pcinc;
  assign memReq   = w_mem_req;
  assign memAddr  = r_mem_addr;
  assign IRout    = r_ir;
  assign IRvalid  = w_ir_valid;
  assign fetchErr = w_fetch_err;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// Bench for fetch_unit: vector table, redirect/reset/timeout sequences and
// randomized traffic against a transaction-level model with its own PC counter.
module tb_fetch_unit;
  localparam int N  = 32;
  localparam int TO = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         run = 1'b0;
  logic         flush = 1'b0;
  logic         memAck = 1'b0;
  logic         IRready = 1'b0;
  logic [N-1:0] PCaddr = '0;
  logic [N-1:0] memRdata = '0;
  logic         PCinc, memReq, IRvalid, fetchErr;
  logic [N-1:0] memAddr, IRout;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fetch_unit #(.n(N), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .flush(flush), .PCaddr(PCaddr),
    .PCinc(PCinc), .memReq(memReq), .memAddr(memAddr), .memRdata(memRdata),
    .memAck(memAck), .IRout(IRout), .IRvalid(IRvalid), .IRready(IRready),
    .fetchErr(fetchErr)
  );

  typedef struct {
    logic         run, flush, ack, ready;
    logic [N-1:0] pc, rdata;
    logic         req;
    logic [N-1:0] addr;
    logic         irv;
    logic [N-1:0] ir;
    logic         inc;
  } vec_t;

  vec_t tbl[13];

  typedef enum int {P_IDLE, P_SAMPLE, P_READ, P_HOLD, P_ERR} phase_t;
  phase_t       m_ph;
  logic         m_drop, m_inc;
  logic [N-1:0] m_addr, m_ir;
`ifdef FETCH_TIMEOUT_EN
  int           m_wait;
`endif

  function automatic vec_t mkv(logic r, logic f, logic a, logic rd, logic [N-1:0] pc,
                               logic [N-1:0] dat, logic req, logic [N-1:0] addr,
                               logic irv, logic [N-1:0] ir, logic inc);
    vec_t v;
    v.run = r; v.flush = f; v.ack = a; v.ready = rd; v.pc = pc; v.rdata = dat;
    v.req = req; v.addr = addr; v.irv = irv; v.ir = ir; v.inc = inc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_outs(input string tag, input logic req, input logic [N-1:0] addr,
                          input logic irv, input logic [N-1:0] ir, input logic inc,
                          input logic err);
    chk({tag, ".memReq"},   32'(memReq),   32'(req));
    chk({tag, ".memAddr"},  memAddr,       addr);
    chk({tag, ".IRvalid"},  32'(IRvalid),  32'(irv));
    chk({tag, ".IRout"},    IRout,         ir);
    chk({tag, ".PCinc"},    32'(PCinc),    32'(inc));
    chk({tag, ".fetchErr"}, 32'(fetchErr), 32'(err));
  endtask

  task automatic drive(input logic r, input logic f, input logic a, input logic rd,
                       input logic [N-1:0] pc, input logic [N-1:0] dat);
    run = r; flush = f; memAck = a; IRready = rd; PCaddr = pc; memRdata = dat;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic model_reset();
    m_ph = P_IDLE; m_drop = 1'b0; m_inc = 1'b0; m_addr = '0; m_ir = '0;
`ifdef FETCH_TIMEOUT_EN
    m_wait = 0;
`endif
  endtask

  // One clock of the fetch rules applied to the inputs currently driven.
  task automatic model_step();
    m_inc = 1'b0;
    case (m_ph)
      P_IDLE: if (run) m_ph = P_SAMPLE;
      P_SAMPLE: begin
        m_addr = PCaddr;
        if (!flush) begin
          m_ph = P_READ; m_drop = 1'b0;
`ifdef FETCH_TIMEOUT_EN
          m_wait = 0;
`endif
        end
      end
      P_READ: begin
        if (memAck) begin
          if (m_drop || flush) m_ph = P_SAMPLE;
          else begin m_ph = P_HOLD; m_ir = memRdata; m_inc = 1'b1; end
        end else if (flush && !m_drop) begin
          m_drop = 1'b1;
`ifdef FETCH_TIMEOUT_EN
          m_wait = 0;
`endif
        end else begin
`ifdef FETCH_TIMEOUT_EN
          m_wait++;
          if (m_wait == TO) m_ph = P_ERR;
`endif
        end
      end
      P_HOLD: if (flush || IRready) m_ph = run ? P_SAMPLE : P_IDLE;
      default: ;
    endcase
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] pc, pc_next;

    tbl[0]  = mkv(1'b1,1'b0,1'b0,1'b0, 32'd32, 32'd0,          1'b0, 32'd0,  1'b0, 32'd0,          1'b0);
    tbl[1]  = mkv(1'b1,1'b0,1'b0,1'b0, 32'd32, 32'd0,          1'b1, 32'd32, 1'b0, 32'd0,          1'b0);
    tbl[2]  = mkv(1'b1,1'b0,1'b1,1'b0, 32'd32, 32'hA5A5_0001,  1'b0, 32'd32, 1'b1, 32'hA5A5_0001,  1'b1);
    tbl[3]  = mkv(1'b1,1'b0,1'b0,1'b1, 32'd33, 32'd0,          1'b0, 32'd32, 1'b0, 32'hA5A5_0001,  1'b0);
    tbl[4]  = mkv(1'b1,1'b0,1'b0,1'b0, 32'd33, 32'd0,          1'b1, 32'd33, 1'b0, 32'hA5A5_0001,  1'b0);
    tbl[5]  = mkv(1'b1,1'b0,1'b1,1'b0, 32'd33, 32'h1234_5678,  1'b0, 32'd33, 1'b1, 32'h1234_5678,  1'b1);
    for (int i = 6; i <= 10; i++)
      tbl[i] = mkv(1'b1,1'b0,1'b1,1'b0, 32'd34, 32'hDEAD_BEEF, 1'b0, 32'd33, 1'b1, 32'h1234_5678,  1'b0);
    tbl[11] = mkv(1'b0,1'b0,1'b0,1'b1, 32'd34, 32'd0,          1'b0, 32'd33, 1'b0, 32'h1234_5678,  1'b0);
    tbl[12] = mkv(1'b0,1'b0,1'b0,1'b0, 32'd34, 32'd0,          1'b0, 32'd33, 1'b0, 32'h1234_5678,  1'b0);

    do_reset();
    chk_outs("reset", 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].run, tbl[i].flush, tbl[i].ack, tbl[i].ready, tbl[i].pc, tbl[i].rdata);
      step();
      chk_outs($sformatf("vec%0d", i), tbl[i].req, tbl[i].addr, tbl[i].irv, tbl[i].ir,
               tbl[i].inc, 1'b0);
    end

    // Redirect while the read is outstanding: drain the old address, drop the data.
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h40, '0);  step(); chk_outs("rd.addr",  1'b0, '0,     1'b0, '0, 1'b0, 1'b0);
    step();                                      chk_outs("rd.fetch", 1'b1, 32'h40, 1'b0, '0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h40, '0);  step(); chk_outs("rd.drain0", 1'b1, 32'h40, 1'b0, '0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h100, '0); step(); chk_outs("rd.drain1", 1'b1, 32'h40, 1'b0, '0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h100, '0); step(); chk_outs("rd.drain2", 1'b1, 32'h40, 1'b0, '0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h100, 32'hBAD0_BAD0); step();
    chk_outs("rd.discard", 1'b0, 32'h40, 1'b0, '0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h100, '0); step(); chk_outs("rd.refetch", 1'b1, 32'h100, 1'b0, '0, 1'b0, 1'b0);

    // Flush colliding with ack in FETCH, then with IRready in HOLD.
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h100, 32'hCAFE_0001); step();
    chk_outs("fa.addr", 1'b0, 32'h100, 1'b0, '0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h200, '0); step(); chk_outs("fa.fetch", 1'b1, 32'h200, 1'b0, '0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h200, 32'h777); step();
    chk_outs("fa.hold", 1'b0, 32'h200, 1'b1, 32'h777, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h300, '0); step(); chk_outs("fr.flush", 1'b0, 32'h200, 1'b0, 32'h777, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h300, '0); step(); chk_outs("fr.next", 1'b1, 32'h300, 1'b0, 32'h777, 1'b0, 1'b0);

    // Asynchronous reset mid-FETCH, then recovery from IDLE.
    #2 rst_n = 1'b0;
    #1 chk_outs("rst.fetch", 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    #1 rst_n = 1'b1;
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h44, '0); step(); chk_outs("rst.idle0", 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    step();                                     chk_outs("rst.idle1", 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h44, '0); step(); chk_outs("rst.addr", 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    step();                                     chk_outs("rst.fetch2", 1'b1, 32'h44, 1'b0, '0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h44, 32'h55); step(); chk_outs("rst.hold", 1'b0, 32'h44, 1'b1, 32'h55, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1 chk_outs("rst.pcinc", 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    #1 rst_n = 1'b1;

    // memAck never arrives.
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h80, '0); step(); step();
    chk_outs("to.fetch", 1'b1, 32'h80, 1'b0, '0, 1'b0, 1'b0);
`ifdef FETCH_TIMEOUT_EN
    for (int i = 1; i < TO; i++) begin
      step(); chk_outs($sformatf("to.wait%0d", i), 1'b1, 32'h80, 1'b0, '0, 1'b0, 1'b0);
    end
    step(); chk_outs("to.err", 1'b0, 32'h80, 1'b0, '0, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h90, 32'h1);
    for (int i = 0; i < 5; i++) begin
      step(); chk_outs($sformatf("to.sticky%0d", i), 1'b0, 32'h80, 1'b0, '0, 1'b0, 1'b1);
    end
`else
    for (int i = 1; i <= 20; i++) begin
      step(); chk_outs($sformatf("to.wait%0d", i), 1'b1, 32'h80, 1'b0, '0, 1'b0, 1'b0);
    end
`endif

    // Random traffic with an upstream PC counter (PCinc advances, flush loads).
    do_reset();
    model_reset();
    pc = 32'h1000;
    for (int c = 0; c < 4000; c++) begin
      chk_outs("rnd", m_ph == P_READ, m_addr, m_ph == P_HOLD, m_ir, m_inc, m_ph == P_ERR);
      if ($urandom_range(0, 299) == 0) begin
        rst_n = 1'b0;
        #1;
        model_reset();
        chk_outs("rnd.rst", 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
        rst_n = 1'b1;
      end
      run      = ($urandom_range(0, 9) != 0);
      flush    = ($urandom_range(0, 9) == 0);
      memAck   = ($urandom_range(0, 99) < 65);
      IRready  = ($urandom_range(0, 1) == 1);
      memRdata = $urandom;
      PCaddr   = pc;
      if (flush)      pc_next = $urandom;
      else if (m_inc) pc_next = pc + 32'd1;
      else            pc_next = pc;
      model_step();
      step();
      pc = pc_next;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
